dvp_capture: RTL and testbench
==============================

Name: dvp_capture

Overview:
- Front-end stage upstream of the Sobel edge pipeline.
- Samples the 8-bit DVP camera bus (VSYNC/HREF/DATA) and assembles byte pairs into RGB565 pixels.
- Emits one-cycle pixel strobes on href/pixel_out plus a re-timed vsync, which drive the Sobel processor's href/vsync/pixel_in directly.
- Aligns capture to frame boundaries, discards warm-up frames and flags malformed lines and frames.

Parameters:
- IMG_WIDTH, 640, expected pixels per line (byte pairs per HREF burst).
- IMG_HEIGHT, 480, expected lines per frame.
- FRAME_SKIP, 2, complete frames discarded after enable before output starts (0 = none).
- VSYNC_ACTIVE_HIGH, 1, polarity of cam_vsync (1: high = blanking/sync).

Ports:
- clk  in  1  pixel clock; cam_* are synchronous to it.
- rst  in  1  asynchronous reset, active-high.
- cam_vsync  in  1  camera frame sync.
- cam_href  in  1  camera line-valid.
- cam_data  in  8  camera byte bus; high byte first.
- capture_enable  in  1  start/stop capture; honoured at frame boundaries only.
- href  out  1  pixel valid strobe, one cycle per pixel.
- vsync  out  1  active-high frame sync, re-timed to the pixel path.
- pixel_out  out  16  RGB565 pixel, valid when href=1.
- frame_done  out  1  one-cycle pulse at the end of each emitted frame.
- frame_count  out  16  emitted-frame counter; wraps 0xFFFF->0.
- line_err  out  1  sticky: an HREF burst had byte count != 2*IMG_WIDTH.
- frame_err  out  1  sticky: a frame had line count != IMG_HEIGHT.

Behaviour:
- Reset (async, rst=1): all outputs 0; state IDLE; byte phase 0; col/row/skip counters 0.
- Input stage: cam_vsync, cam_href and cam_data are registered once (s1). Polarity is normalised so that vs = 1 means sync active.
- States:
  - IDLE: wait for capture_enable=1 -> WAIT_SYNC.
  - WAIT_SYNC: wait for a vs falling edge (sync->active). If skip_cnt < FRAME_SKIP -> SKIP, else -> CAPTURE. Data ignored.
  - SKIP: discard data. At the vs rising edge, skip_cnt++ and return to WAIT_SYNC.
  - CAPTURE: assemble pixels. At the vs rising edge:
    - frame_done pulses one cycle; frame_count++.
    - frame_err is set if row != IMG_HEIGHT.
    - row clears.
    - If capture_enable=0: go to IDLE and clear skip_cnt. Otherwise go to WAIT_SYNC with skip_cnt held at FRAME_SKIP, so no further skipping.
- Deasserting capture_enable mid-frame never truncates the frame; it takes effect at the next vs rising edge. While in WAIT_SYNC or SKIP, capture_enable=0 -> IDLE.
- Byte assembly (CAPTURE, s1 href=1):
  - Phase 0 latches the high byte.
  - Phase 1 forms {hi, lo} and registers it to pixel_out with href=1 on the next edge. Latency is 2 clk from the low byte on the pins to href high.
  - href is otherwise 0; pixel_out holds its last value.
- Counters:
  - col increments per emitted pixel and saturates at 0x7FF.
  - On the s1 href falling edge: line_err is set if col != IMG_WIDTH or phase=1 (odd byte); the dangling high byte is dropped; phase and col clear; row++.
  - href=1 outside CAPTURE never produces output.
- vsync output: vs delayed 2 cycles, so it is aligned with the pixel path. Driven only in CAPTURE and at the closing edge; 0 in IDLE, WAIT_SYNC and SKIP.
- Simultaneous vs rise and href high in s1: vs wins. The partial line is closed with the line_err check applied, and the frame ends.
- line_err and frame_err clear only on rst.

Optional Feature:
- Macro: DVP_CAPTURE_TESTPAT_EN.
- Defined: adds input testpat_sel (1 bit). When testpat_sel=1, pixel_out is replaced by 8 vertical colour bars of IMG_WIDTH/8 pixels each, indexed by col. Bar order: white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000. Timing, href, counters and error flags are unchanged; camera data is consumed and discarded.
- Undefined: no port; camera data always passes through.

Test Plan:
- Bench parameters for all scenarios: IMG_WIDTH=4, IMG_HEIGHT=2, FRAME_SKIP=1.
- Reset mid-CAPTURE: assert rst while href=1 -> href, vsync, frame_done, frame_count and both error flags are 0 immediately; IDLE resumes after release.
- Enable, then 3 well-formed frames with bytes 0x12,0x34,... -> frame 1 is skipped (no href). Frames 2 and 3 each give 8 href pulses with pixel_out=0x1234, 0x5678, ... and href 2 clk after each low byte. frame_done pulses twice; frame_count=2; no errors.
- Line of 7 bytes in CAPTURE -> 3 pixels emitted, last byte dropped, line_err=1, frame_err stays 0 if the line count is correct.
- Frame with 3 lines -> frame_err=1 at the vs rise; frame_count still increments.
- Drop capture_enable mid-line -> the current frame completes with all 8 pixels and frame_done, then IDLE with no output for the following frame.
- With DVP_CAPTURE_TESTPAT_EN and testpat_sel=1, IMG_WIDTH=8 -> the line emits FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.

Source files
------------

// File: rtl/dvp_capture.sv
// DVP camera front end: registers the 8-bit camera bus and assembles byte pairs into RGB565
// pixels for the Sobel pipeline. Define DVP_CAPTURE_TESTPAT_EN to add a colour-bar source.
module dvp_capture #(
    parameter int unsigned IMG_WIDTH         = 640,
    parameter int unsigned IMG_HEIGHT        = 480,
    parameter int unsigned FRAME_SKIP        = 2,
    parameter int unsigned VSYNC_ACTIVE_HIGH = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        capture_enable,
`ifdef DVP_CAPTURE_TESTPAT_EN
    input  logic        testpat_sel,
`endif
    output logic        href,
    output logic        vsync,
    output logic [15:0] pixel_out,
    output logic        frame_done,
    output logic [15:0] frame_count,
    output logic        line_err,
    output logic        frame_err
);

    typedef enum logic [1:0] {StIdle, StWaitSync, StSkip, StCapture} state_e;

    state_e      state_q;
    logic        vs_s1, vs_q, href_s1, href_q, phase_q;
    logic [7:0]  data_s1, hi_q, skip_q;
    logic [10:0] col_q, row_q;

    logic        vs_raw, vs_rise, vs_fall, href_fall, line_close;
    logic [10:0] row_end;
    logic [15:0] pix_word;

`ifdef DVP_CAPTURE_TESTPAT_EN
    localparam int unsigned BarW = (IMG_WIDTH >= 8) ? IMG_WIDTH / 8 : 1;

    function automatic logic [15:0] bar_colour(input logic [10:0] c);
        logic [10:0] bar;
        bar = c / 11'(BarW);
        case (bar)
            11'd0:   bar_colour = 16'hFFFF;
            11'd1:   bar_colour = 16'hFFE0;
            11'd2:   bar_colour = 16'h07FF;
            11'd3:   bar_colour = 16'h07E0;
            11'd4:   bar_colour = 16'hF81F;
            11'd5:   bar_colour = 16'hF800;
            11'd6:   bar_colour = 16'h001F;
            default: bar_colour = 16'h0000;
        endcase
    endfunction
`endif

    assign vs_raw = (VSYNC_ACTIVE_HIGH != 0) ? cam_vsync : ~cam_vsync;

    always_comb begin
        vs_rise    = vs_s1 & ~vs_q;
        vs_fall    = ~vs_s1 & vs_q;
        href_fall  = ~href_s1 & href_q;
        // A line still open when sync rises is closed (and counted) by the frame end.
        line_close = href_fall | (vs_rise & href_s1);
        row_end    = (line_close && row_q != 11'h7FF) ? row_q + 11'd1 : row_q;
        pix_word   = {hi_q, data_s1};
`ifdef DVP_CAPTURE_TESTPAT_EN
        if (testpat_sel) pix_word = bar_colour(col_q);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            vs_s1       <= 1'b0;
            vs_q        <= 1'b0;
            href_s1     <= 1'b0;
            href_q      <= 1'b0;
            data_s1     <= 8'h00;
            hi_q        <= 8'h00;
            phase_q     <= 1'b0;
            skip_q      <= 8'h00;
            col_q       <= 11'd0;
            row_q       <= 11'd0;
            href        <= 1'b0;
            vsync       <= 1'b0;
            pixel_out   <= 16'h0000;
            frame_done  <= 1'b0;
            frame_count <= 16'h0000;
            line_err    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            vs_s1      <= vs_raw;
            vs_q       <= vs_s1;
            href_s1    <= cam_href;
            href_q     <= href_s1;
            data_s1    <= cam_data;
            href       <= 1'b0;
            frame_done <= 1'b0;
            vsync      <= (state_q == StCapture) ? vs_s1 : 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (capture_enable) state_q <= StWaitSync;
                end
                StWaitSync: begin
                    if (!capture_enable) begin
                        state_q <= StIdle;
                        skip_q  <= 8'h00;
                    end else if (vs_fall) begin
                        state_q <= (skip_q < 8'(FRAME_SKIP)) ? StSkip : StCapture;
                    end
                end
                StSkip: begin
                    if (!capture_enable) begin
                        state_q <= StIdle;
                        skip_q  <= 8'h00;
                    end else if (vs_rise) begin
                        skip_q  <= skip_q + 8'd1;
                        state_q <= StWaitSync;
                    end
                end
                StCapture: begin
                    if (line_close) begin
                        if (col_q != 11'(IMG_WIDTH) || phase_q) line_err <= 1'b1;
                        phase_q <= 1'b0;
                        col_q   <= 11'd0;
                        row_q   <= row_end;
                    end
                    if (vs_rise) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        if (row_end != 11'(IMG_HEIGHT)) frame_err <= 1'b1;
                        row_q   <= 11'd0;
                        col_q   <= 11'd0;
                        phase_q <= 1'b0;
                        if (!capture_enable) begin
                            state_q <= StIdle;
                            skip_q  <= 8'h00;
                        end else begin
                            state_q <= StWaitSync;
                            skip_q  <= 8'(FRAME_SKIP);
                        end
                    end else if (href_s1) begin
                        if (!phase_q) begin
                            hi_q    <= data_s1;
                            phase_q <= 1'b1;
                        end else begin
                            pixel_out <= pix_word;
                            href      <= 1'b1;
                            phase_q   <= 1'b0;
                            if (col_q != 11'h7FF) col_q <= col_q + 11'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dvp_capture.sv
// Scoreboard bench for dvp_capture: driver pushes expected pixels and arrival cycles,
// a negedge monitor pops and compares whenever href is high.
module tb_dvp_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'h00;
    logic        capture_enable = 1'b0;
    logic        href, vsync, frame_done, line_err, frame_err;
    logic [15:0] pixel_out, frame_count;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cnt = 0;
    logic [47:0] exp_q[$];
    logic [47:0] mon_e;
    logic [7:0]  bv, hi_b;

    dvp_capture #(
        .IMG_WIDTH(4),
        .IMG_HEIGHT(2),
        .FRAME_SKIP(1),
        .VSYNC_ACTIVE_HIGH(1)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .cam_vsync(cam_vsync),
        .cam_href(cam_href),
        .cam_data(cam_data),
        .capture_enable(capture_enable),
`ifdef DVP_CAPTURE_TESTPAT_EN
        .testpat_sel(1'b0),
`endif
        .href(href),
        .vsync(vsync),
        .pixel_out(pixel_out),
        .frame_done(frame_done),
        .frame_count(frame_count),
        .line_err(line_err),
        .frame_err(frame_err)
    );

`ifdef DVP_CAPTURE_TESTPAT_EN
    logic        tp_en = 1'b0;
    bit          tp_mode = 1'b0;
    logic        tp_href, tp_vsync, tp_done, tp_lerr, tp_ferr;
    logic [15:0] tp_pix, tp_cnt;
    logic [47:0] tp_q[$];
    logic [47:0] tp_e;
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    dvp_capture #(
        .IMG_WIDTH(8),
        .IMG_HEIGHT(1),
        .FRAME_SKIP(0),
        .VSYNC_ACTIVE_HIGH(1)
    ) u_tp (
        .clk(clk),
        .rst(rst),
        .cam_vsync(cam_vsync),
        .cam_href(cam_href),
        .cam_data(cam_data),
        .capture_enable(tp_en),
        .testpat_sel(1'b1),
        .href(tp_href),
        .vsync(tp_vsync),
        .pixel_out(tp_pix),
        .frame_done(tp_done),
        .frame_count(tp_cnt),
        .line_err(tp_lerr),
        .frame_err(tp_ferr)
    );
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every href pulse must match the head of the scoreboard, value and cycle.
    always @(negedge clk) begin
        if (!rst && frame_done) done_cnt++;
        if (!rst && href) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_href: pixel %h with nothing expected", pixel_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("pixel", {16'h0, pixel_out}, {16'h0, mon_e[15:0]});
                check("pixel_cycle", cyc, mon_e[47:16]);
            end
        end
    end

`ifdef DVP_CAPTURE_TESTPAT_EN
    always @(negedge clk) begin
        if (!rst && tp_href) begin
            if (tp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tp_href: pixel %h with nothing expected", tp_pix);
            end else begin
                tp_e = tp_q.pop_front();
                check("tp_pixel", {16'h0, tp_pix}, {16'h0, tp_e[15:0]});
                check("tp_cycle", cyc, tp_e[47:16]);
            end
        end
    end
`endif

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame_start();
        cam_vsync = 1'b1;
        tick(4);
        cam_vsync = 1'b0;
        bv = 8'h12;
        tick(3);
    endtask

    task automatic vs_close();
        cam_vsync = 1'b1;
        tick(5);
    endtask

    // Low byte on the pins now -> href expected two cycles later.
    task automatic send_line(input int nbytes, input bit emit, input int drop_at);
        cam_href = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            cam_data = bv;
            if (i == drop_at) capture_enable = 1'b0;
            if (i % 2 == 0) hi_b = bv;
            else if (emit) begin
`ifdef DVP_CAPTURE_TESTPAT_EN
                if (tp_mode) tp_q.push_back({32'(cyc + 2), bars[i / 2]});
                else exp_q.push_back({32'(cyc + 2), hi_b, bv});
`else
                exp_q.push_back({32'(cyc + 2), hi_b, bv});
`endif
            end
            bv = bv + 8'h22;
            tick(1);
        end
        cam_href = 1'b0;
        tick(3);
    endtask

    task automatic frame(input int nlines, input int nbytes, input bit emit);
        frame_start();
        for (int l = 0; l < nlines; l++) send_line(nbytes, emit, -1);
    endtask

    initial begin
        tick(2);
        check("rst_href", href, 0);
        check("rst_vsync", vsync, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_line_err", line_err, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        tick(2);

        // One skipped frame, then two captured frames.
        capture_enable = 1'b1;
        tick(2);
        frame(2, 8, 1'b0);
        frame(2, 8, 1'b1);
        frame(2, 8, 1'b1);
        vs_close();
        check("good_done_cnt", done_cnt, 2);
        check("good_frame_count", frame_count, 2);
        check("good_line_err", line_err, 0);
        check("good_frame_err", frame_err, 0);
        check("good_pending", exp_q.size(), 0);

        // Odd-length line: three pixels, dangling byte dropped.
        frame_start();
        send_line(7, 1'b1, -1);
        send_line(8, 1'b1, -1);
        vs_close();
        check("short_line_err", line_err, 1);
        check("short_frame_err", frame_err, 0);
        check("short_frame_count", frame_count, 3);
        check("short_pending", exp_q.size(), 0);

        // Three lines in a two-line frame.
        frame(3, 8, 1'b1);
        vs_close();
        check("tall_frame_err", frame_err, 1);
        check("tall_frame_count", frame_count, 4);
        check("tall_done_cnt", done_cnt, 4);

        // Disable mid-line: frame completes, next frame ignored.
        frame_start();
        send_line(8, 1'b1, 3);
        send_line(8, 1'b1, -1);
        vs_close();
        check("drop_frame_count", frame_count, 5);
        check("drop_done_cnt", done_cnt, 5);
        frame(2, 8, 1'b0);
        vs_close();
        check("idle_frame_count", frame_count, 5);
        check("idle_done_cnt", done_cnt, 5);
        check("idle_vsync", vsync, 0);
        check("idle_pending", exp_q.size(), 0);

        // Reset while a line is streaming in CAPTURE.
        capture_enable = 1'b1;
        tick(1);
        frame(2, 8, 1'b0);
        frame_start();
        cam_href = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cam_data = bv;
            if (i % 2 == 0) hi_b = bv;
            else exp_q.push_back({32'(cyc + 2), hi_b, bv});
            bv = bv + 8'h22;
            tick(1);
        end
        cam_data = bv;
        tick(1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_href", href, 0);
        check("mid_rst_vsync", vsync, 0);
        check("mid_rst_frame_done", frame_done, 0);
        check("mid_rst_frame_count", frame_count, 0);
        check("mid_rst_line_err", line_err, 0);
        check("mid_rst_frame_err", frame_err, 0);
        cam_href = 1'b0;
        capture_enable = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(2);
        frame(2, 8, 1'b0);
        vs_close();
        check("post_rst_frame_count", frame_count, 0);
        check("post_rst_done_cnt", done_cnt, 5);
        check("post_rst_pending", exp_q.size(), 0);

`ifdef DVP_CAPTURE_TESTPAT_EN
        tp_en = 1'b1;
        tp_mode = 1'b1;
        tick(1);
        frame_start();
        send_line(16, 1'b1, -1);
        vs_close();
        tp_mode = 1'b0;
        check("tp_pending", tp_q.size(), 0);
        check("tp_line_err", tp_lerr, 0);
        check("tp_frame_count", tp_cnt, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
